// File: rtl/vram_fill_writer.sv
// rtl/vram_fill_writer.sv - rectangle fill engine for the write port of the background VRAM
// Clips each command to the canvas and writes one pixel per clock in raster order, gated by wr_win.
module vram_fill_writer #(
  parameter int WIDTH  = 960,
  parameter int HEIGHT = 480,
  parameter int ADR_W  = 19,
  parameter int DAT_W  = 9
) (
  input  logic             clk_25mhz,
  input  logic             RST_N,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [9:0]       cmd_x,
  input  logic [8:0]       cmd_y,
  input  logic [9:0]       cmd_w,
  input  logic [8:0]       cmd_h,
  input  logic [DAT_W-1:0] cmd_color,
  input  logic             wr_win,
  output logic             vram_we,
  output logic [ADR_W-1:0] vram_adr,
  output logic [DAT_W-1:0] vram_din,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

  localparam logic [10:0]      WIDTH_X  = 11'(WIDTH);
  localparam logic [9:0]       HEIGHT_Y = 10'(HEIGHT);
  localparam logic [ADR_W-1:0] STRIDE   = ADR_W'(WIDTH);

  state_t             state_q, state_d;
  logic [9:0]         x_q, x_d, w_q, w_d, cw_q, cw_d, col_q, col_d;
  logic [8:0]         y_q, y_d, h_q, h_d, ch_q, ch_d, row_q, row_d;
  logic [DAT_W-1:0]   color_q, color_d;
  logic [ADR_W-1:0]   base_q, base_d, adr_q, adr_d;
  logic               out_en_q, out_en_d;

  logic               x_in, y_in;
  logic [9:0]         x_rem, clip_w;
  logic [8:0]         y_rem, clip_h;
  logic [ADR_W-1:0]   row_base;

  // Remaining canvas extent is only meaningful when the origin lies inside the canvas.
  always_comb begin
    x_in     = {1'b0, x_q} < WIDTH_X;
    y_in     = {1'b0, y_q} < HEIGHT_Y;
    x_rem    = 10'(WIDTH_X - {1'b0, x_q});
    y_rem    = 9'(HEIGHT_Y - {1'b0, y_q});
    clip_w   = (w_q < x_rem) ? w_q : x_rem;
    clip_h   = (h_q < y_rem) ? h_q : y_rem;
    row_base = ADR_W'(y_q) * STRIDE + ADR_W'(x_q);
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    w_d      = w_q;
    h_d      = h_q;
    cw_d     = cw_q;
    ch_d     = ch_q;
    col_d    = col_q;
    row_d    = row_q;
    color_d  = color_q;
    base_d   = base_q;
    adr_d    = adr_q;
    out_en_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          x_d     = cmd_x;
          y_d     = cmd_y;
          w_d     = cmd_w;
          h_d     = cmd_h;
          color_d = cmd_color;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (!x_in || !y_in || w_q == 10'd0 || h_q == 9'd0) begin
          state_d = DONE;
        end else begin
          cw_d    = clip_w;
          ch_d    = clip_h;
          base_d  = row_base;
          adr_d   = row_base;
          col_d   = 10'd0;
          row_d   = 9'd0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (wr_win) begin
          if (col_q < cw_q - 10'd1) begin
            col_d = col_q + 10'd1;
            adr_d = adr_q + 1'b1;
          end else if (row_q < ch_q - 9'd1) begin
            col_d  = 10'd0;
            row_d  = row_q + 9'd1;
            base_d = base_q + STRIDE;
            adr_d  = base_q + STRIDE;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_25mhz) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      w_q      <= '0;
      h_q      <= '0;
      cw_q     <= '0;
      ch_q     <= '0;
      col_q    <= '0;
      row_q    <= '0;
      color_q  <= '0;
      base_q   <= '0;
      adr_q    <= '0;
      out_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      w_q      <= w_d;
      h_q      <= h_d;
      cw_q     <= cw_d;
      ch_q     <= ch_d;
      col_q    <= col_d;
      row_q    <= row_d;
      color_q  <= color_d;
      base_q   <= base_d;
      adr_q    <= adr_d;
      out_en_q <= out_en_d;
    end
  end

  // out_en_q keeps cmd_ready low until the first edge that sees reset released.
  assign cmd_ready = (state_q == IDLE) && out_en_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign vram_we   = (state_q == FILL) && wr_win;
  assign vram_adr  = adr_q;
  assign vram_din  = color_q;

endmodule
